// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared constants for the MEM pipeline stage: MEMctrl bit positions, the
// bus sequencer state encoding and the position of the P/V flag.
// No ports.
package mem_stage_pkg;

    // MEMctrl bit positions
    localparam int MC_RSVD = 0;
    localparam int MC_RD   = 1;
    localparam int MC_IORQ = 2;
    localparam int MC_LOAD = 3;
    localparam int MC_MREQ = 4;
    localparam int MC_PFIX = 5;
    localparam int MC_WR   = 6;
    localparam int MC_WORD = 7;

    // Parity/overflow flag position inside Flags
    localparam int FLAG_PV = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } bus_state_t;

endpackage

// File: rtl/mem_bus_seq.sv
// mem_bus_seq
// Bus sequencer for the MEM stage: walks one or two byte beats over the
// shared memory/IO bus, honours D_wait, and aborts an access whose current
// beat has waited TMO_CYC consecutive cycles (TMO_CYC = 0 never aborts).
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   req             access requested (IORQ or MREQ in MEMctrl)
//   is_word         two-beat access
//   rd_en..mreq_en  strobe selects taken from MEMctrl
//   base_addr       beat 0 address, beat 1 uses base_addr+1 (wraps)
//   wr_data         store data, low byte on beat 0, high byte on beat 1
//   D_wait          bus wait request
//   D_addr, D_data_out, IORQ, MREQ, RD, WR   bus outputs, 0 when idle
//   done            final beat completes this cycle
//   beat0_done      first beat completes this cycle (capture low byte)
//   abort_now       access aborted by timeout this cycle
//   stall           hold upstream stages
//   bus_timeout     registered one-cycle pulse after an abort
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no beat held; a new request drives beat 0 combinationally
// ST_LO   | beat 0 waited at least once, still driving beat 0
// ST_HI   | beat 1 of a word access, address base_addr+1
module mem_bus_seq
    import mem_stage_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 8,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req,
    input  logic                  is_word,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic                  iorq_en,
    input  logic                  mreq_en,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  D_wait,
    output logic [ADDR_W-1:0]     D_addr,
    output logic [DATA_W-1:0]     D_data_out,
    output logic                  IORQ,
    output logic                  MREQ,
    output logic                  RD,
    output logic                  WR,
    output logic                  done,
    output logic                  beat0_done,
    output logic                  abort_now,
    output logic                  stall,
    output logic                  bus_timeout
);

    // Counter only needs to reach TMO_CYC-1: the abort fires on the wait
    // cycle that would make it TMO_CYC.
    localparam int              CNT_W    = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic            TMO_EN   = (TMO_CYC != 0);

    bus_state_t       state;
    bus_state_t       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             beat_hi;

    assign beat_hi   = (state == ST_HI);
    assign abort_now = TMO_EN && req && D_wait && (wait_cnt == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            bus_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus_timeout <= abort_now;
            // A completing beat clears the count, so each beat starts at 0.
            if (!req || !D_wait || abort_now)
                wait_cnt <= '0;
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (!req || abort_now) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_word && !D_wait)
                        state_nxt = ST_HI;
                    else if (D_wait)
                        state_nxt = ST_LO;
                end
                ST_LO: begin
                    if (!D_wait)
                        state_nxt = is_word ? ST_HI : ST_IDLE;
                end
                ST_HI: begin
                    if (!D_wait)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        D_addr     = '0;
        D_data_out = '0;
        IORQ       = 1'b0;
        MREQ       = 1'b0;
        RD         = 1'b0;
        WR         = 1'b0;
        done       = req && !D_wait && (beat_hi || !is_word);
        beat0_done = req && !D_wait && !beat_hi;
        stall      = req && !(done || abort_now);
        if (req) begin
            D_addr = beat_hi ? base_addr + ADDR_W'(1) : base_addr;
            IORQ   = iorq_en;
            MREQ   = mreq_en;
            RD     = rd_en;
            WR     = wr_en;
            if (wr_en)
                D_data_out = beat_hi ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/mem_stage_gen.sv
// mem_stage_gen
// MEM pipeline stage between EXE and WB. Runs byte/word accesses on the
// shared memory/IO bus through mem_bus_seq, builds the writeback result
// (sign-extended byte, little-endian word, ALU result, or all ones after a
// timeout) and registers it into the MEM/WB latch whenever the stage is not
// stalled. A flush loads a bubble (Wr_id_out=0, Fmask_out=0) when the
// current entry retires; a started bus access always runs to completion.
//
// Optional build macro: MEM_PARITY_FIX_EN -- byte loads with MEMctrl[5]
// overwrite the P/V flag with the even parity of the loaded byte.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   Wr_id, Fmask, Flags       EXE payload carried to WB
//   MEMctrl                   access control (RD/IORQ/load/MREQ/pfix/WR/word)
//   Src1                      store data
//   Result                    ALU result / access address
//   flush                     squash the current MEM/WB entry
//   D_addr, D_data_in, D_data_out, IORQ, MREQ, RD, WR, D_wait   bus
//   Wr_id_out, Fmask_out, Result_out, Flags_out                 MEM/WB latch
//   mem_pipe_stall            hold upstream stages
//   bus_timeout               one-cycle pulse after an aborted access
module mem_stage_gen
    import mem_stage_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 8,
    parameter int          RES_W   = 16,   // must be 2*DATA_W
    parameter int unsigned TMO_CYC = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4:0]        Wr_id,
    input  logic [7:0]        Fmask,
    input  logic [7:0]        MEMctrl,
    input  logic [RES_W-1:0]  Src1,
    input  logic [RES_W-1:0]  Result,
    input  logic [7:0]        Flags,
    input  logic              flush,
    output logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_data_in,
    output logic [DATA_W-1:0] D_data_out,
    output logic              IORQ,
    output logic              MREQ,
    output logic              RD,
    output logic              WR,
    input  logic              D_wait,
    output logic [4:0]        Wr_id_out,
    output logic [7:0]        Fmask_out,
    output logic [RES_W-1:0]  Result_out,
    output logic [7:0]        Flags_out,
    output logic              mem_pipe_stall,
    output logic              bus_timeout
);

    logic              req;
    logic              is_word;
    logic              load_sel;
    logic              done;
    logic              beat0_done;
    logic              abort_now;
    logic [ADDR_W-1:0] base_addr;
    logic [DATA_W-1:0] lo_q;
    logic [RES_W-1:0]  res_nxt;
    logic [7:0]        flags_nxt;
    logic              flush_pend;
    logic              bubble;
    logic              unused_ctrl;

    assign req       = MEMctrl[MC_IORQ] | MEMctrl[MC_MREQ];
    assign is_word   = MEMctrl[MC_WORD];
    assign load_sel  = MEMctrl[MC_LOAD] & req;
    assign base_addr = ADDR_W'(Result);
    // A flush seen while stalled is remembered until the entry retires.
    assign bubble    = flush | flush_pend;

    mem_bus_seq #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TMO_CYC (TMO_CYC)
    ) u_bus_seq (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .is_word     (is_word),
        .rd_en       (MEMctrl[MC_RD]),
        .wr_en       (MEMctrl[MC_WR]),
        .iorq_en     (MEMctrl[MC_IORQ]),
        .mreq_en     (MEMctrl[MC_MREQ]),
        .base_addr   (base_addr),
        .wr_data     (Src1),
        .D_wait      (D_wait),
        .D_addr      (D_addr),
        .D_data_out  (D_data_out),
        .IORQ        (IORQ),
        .MREQ        (MREQ),
        .RD          (RD),
        .WR          (WR),
        .done        (done),
        .beat0_done  (beat0_done),
        .abort_now   (abort_now),
        .stall       (mem_pipe_stall),
        .bus_timeout (bus_timeout)
    );

    always_comb begin
        res_nxt = Result;
        if (abort_now)
            res_nxt = '1;
        else if (load_sel)
            res_nxt = is_word ? {D_data_in, lo_q}
                              : {{(RES_W-DATA_W){D_data_in[DATA_W-1]}}, D_data_in};
    end

`ifdef MEM_PARITY_FIX_EN
    always_comb begin
        flags_nxt = Flags;
        if (load_sel && !is_word && MEMctrl[MC_PFIX] && !abort_now)
            flags_nxt[FLAG_PV] = ~^D_data_in;
    end
    assign unused_ctrl = MEMctrl[MC_RSVD] ^ done;
`else
    assign flags_nxt   = Flags;
    assign unused_ctrl = MEMctrl[MC_RSVD] ^ MEMctrl[MC_PFIX] ^ done;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            Wr_id_out  <= '0;
            Fmask_out  <= '0;
            Result_out <= '0;
            Flags_out  <= '0;
            lo_q       <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (beat0_done)
                lo_q <= D_data_in;
            if (!mem_pipe_stall) begin
                Wr_id_out  <= bubble ? 5'd0 : Wr_id;
                Fmask_out  <= bubble ? 8'd0 : Fmask;
                Result_out <= res_nxt;
                Flags_out  <= flags_nxt;
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_gen.sv
module tb_mem_stage_gen;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  Wr_id = '0;
    logic [7:0]  Fmask = '0;
    logic [7:0]  MEMctrl = '0;
    logic [15:0] Src1 = '0;
    logic [15:0] Result = '0;
    logic [7:0]  Flags = '0;
    logic        flush = 1'b0;
    logic [15:0] D_addr;
    logic [7:0]  D_data_in = '0;
    logic [7:0]  D_data_out;
    logic        IORQ, MREQ, RD, WR;
    logic        D_wait = 1'b0;
    logic [4:0]  Wr_id_out;
    logic [7:0]  Fmask_out;
    logic [15:0] Result_out;
    logic [7:0]  Flags_out;
    logic        mem_pipe_stall;
    logic        bus_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_gen #(
        .ADDR_W  (16),
        .DATA_W  (8),
        .RES_W   (16),
        .TMO_CYC (TMO)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Wr_id          (Wr_id),
        .Fmask          (Fmask),
        .MEMctrl        (MEMctrl),
        .Src1           (Src1),
        .Result         (Result),
        .Flags          (Flags),
        .flush          (flush),
        .D_addr         (D_addr),
        .D_data_in      (D_data_in),
        .D_data_out     (D_data_out),
        .IORQ           (IORQ),
        .MREQ           (MREQ),
        .RD             (RD),
        .WR             (WR),
        .D_wait         (D_wait),
        .Wr_id_out      (Wr_id_out),
        .Fmask_out      (Fmask_out),
        .Result_out     (Result_out),
        .Flags_out      (Flags_out),
        .mem_pipe_stall (mem_pipe_stall),
        .bus_timeout    (bus_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(v[i]);
        return (ones % 2) == 0;
    endfunction

    // One instruction through MEM, acting as the bus slave. Expected values
    // come from the access rules: beat b at Result+b, store byte b of Src1,
    // a beat waiting TMO cycles aborts, result chosen from load type.
    task automatic do_op(input logic [7:0] ctrl, input logic [15:0] res, input logic [15:0] src,
                         input logic [7:0] fl, input int w0, input int w1, input int flush_at,
                         input int dfix0, input int dfix1);
        logic        is_acc, word, aborted, waiting, tmo_hit, last, bub;
        logic [7:0]  d [2];
        int          w [2];
        int          nb, cyc;
        logic [4:0]  id;
        logic [7:0]  fm, exp_fl;
        logic [15:0] exp_res;
        id      = 5'($urandom_range(1, 31));
        fm      = 8'($urandom_range(1, 255));
        is_acc  = ctrl[2] | ctrl[4];
        word    = ctrl[7];
        nb      = (is_acc && word) ? 2 : 1;
        w[0]    = is_acc ? w0 : 0;
        w[1]    = w1;
        d[0]    = (dfix0 < 0) ? 8'($urandom) : 8'(dfix0);
        d[1]    = (dfix1 < 0) ? 8'($urandom) : 8'(dfix1);
        aborted = 1'b0;
        cyc     = 0;
        MEMctrl = ctrl; Result = res; Src1 = src; Wr_id = id; Fmask = fm; Flags = fl;
        for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c <= w[b]; c++) begin
                waiting   = is_acc && (c < w[b]);
                tmo_hit   = waiting && (c + 1 == TMO);
                last      = !waiting && (b == nb - 1);
                flush     = (cyc == flush_at);
                D_wait    = waiting;
                D_data_in = waiting ? 8'($urandom) : d[b];
                @(negedge CLK);
                chk("addr", D_addr, is_acc ? 16'(res + 16'(b)) : 16'h0);
                chk("strobes", {IORQ, MREQ, RD, WR},
                    is_acc ? {ctrl[2], ctrl[4], ctrl[1], ctrl[6]} : 4'h0);
                chk("dout", D_data_out,
                    (is_acc && ctrl[6]) ? ((b == 0) ? src[7:0] : src[15:8]) : 8'h0);
                chk("stall", mem_pipe_stall, is_acc && !(last || tmo_hit));
                @(posedge CLK); #1;
                cyc++;
                if (tmo_hit) begin
                    aborted = 1'b1;
                    break;
                end
            end
        end
        flush = 1'b0; MEMctrl = 8'h00; D_wait = 1'b0;
        if (aborted)
            exp_res = 16'hFFFF;
        else if (is_acc && ctrl[3])
            exp_res = word ? {d[1], d[0]} : {{8{d[0][7]}}, d[0]};
        else
            exp_res = res;
        exp_fl = fl;
`ifdef MEM_PARITY_FIX_EN
        if (is_acc && ctrl[3] && !word && ctrl[5] && !aborted)
            exp_fl[2] = even_par(d[0]);
`endif
        bub = (flush_at >= 0) && (flush_at < cyc);
        chk("wr_id_out", Wr_id_out, bub ? 5'd0 : id);
        chk("fmask_out", Fmask_out, bub ? 8'd0 : fm);
        chk("result_out", Result_out, exp_res);
        chk("flags_out", Flags_out, exp_fl);
        chk("tmo_pulse", bus_timeout, aborted);
        @(posedge CLK); #1;
        chk("tmo_clear", bus_timeout, 1'b0);
        chk("idle_addr", D_addr, 16'h0);
    endtask

    initial begin
        int w0, w1, fa;
        // reset
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wr_id", Wr_id_out, 5'd0);
        chk("rst_fmask", Fmask_out, 8'd0);
        chk("rst_result", Result_out, 16'd0);
        chk("rst_flags", Flags_out, 8'd0);
        chk("rst_tmo", bus_timeout, 1'b0);
        chk("rst_stall", mem_pipe_stall, 1'b0);
        chk("rst_strobes", {IORQ, MREQ, RD, WR}, 4'h0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // byte load, sign extension
        do_op(8'h1A, 16'h1234, 16'h0000, 8'h00, 0, 0, -1, 8'h80, -1);
        // word store across 0xFFFF wrap, two waits on beat 1
        do_op(8'hD0, 16'hFFFF, 16'hBEEF, 8'h00, 0, 2, -1, -1, -1);
        // IN with parity fix request
        do_op(8'h2E, 16'h0012, 16'h0000, 8'h00, 0, 0, -1, 8'h03, -1);
        do_op(8'h2E, 16'h0012, 16'h0000, 8'hFF, 1, 0, -1, 8'h07, -1);
        // word load with waits on both beats
        do_op(8'h9A, 16'h8000, 16'h0000, 8'h11, 2, 1, -1, 8'h34, 8'h12);
        // timeouts on beat 0 and on beat 1
        do_op(8'h1A, 16'h2000, 16'h0000, 8'h5A, 9, 0, -1, -1, -1);
        do_op(8'h9A, 16'h3000, 16'h0000, 8'h00, 1, 7, -1, -1, -1);
        // flush during a waited store, flush with no access, plain pass-through
        do_op(8'h50, 16'h0100, 16'h00A5, 8'h00, 3, 0, 1, -1, -1);
        do_op(8'h00, 16'h5555, 16'h0000, 8'h33, 0, 0, 0, -1, -1);
        do_op(8'h00, 16'h7777, 16'h0000, 8'hC3, 0, 0, -1, -1, -1);

        // reset while beat 1 is on the bus
        MEMctrl = 8'h9A; Result = 16'h4000; D_wait = 1'b0; D_data_in = 8'h11;
        Wr_id = 5'd9; Fmask = 8'h0F; Flags = 8'hAA;
        @(posedge CLK); #1;
        D_wait = 1'b1;
        @(negedge CLK);
        chk("rst_hi_addr", D_addr, 16'h4001);
        RST = 1'b1; MEMctrl = 8'h00;
        @(posedge CLK); #1;
        chk("rst_hi_strobes", {IORQ, MREQ, RD, WR}, 4'h0);
        chk("rst_hi_addr0", D_addr, 16'h0);
        chk("rst_hi_stall", mem_pipe_stall, 1'b0);
        chk("rst_hi_wr_id", Wr_id_out, 5'd0);
        chk("rst_hi_fmask", Fmask_out, 8'd0);
        chk("rst_hi_result", Result_out, 16'd0);
        chk("rst_hi_flags", Flags_out, 8'd0);
        chk("rst_hi_tmo", bus_timeout, 1'b0);
        RST = 1'b0; D_wait = 1'b0;
        @(posedge CLK); #1;

        // randomized instructions
        for (int k = 0; k < 60; k++) begin
            w0 = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 2));
            w1 = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 2));
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            do_op(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), w0, w1, fa, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
